// File: rtl/vc_pkg.sv
// vc_pkg: shared FSM states and vector-word layout for vector_checker (VECTOR_CHECKER_MASK_EN adds the care field)
package vc_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_DATA, APPLY, SETTLE_WAIT, CHECK, DONE} state_t;
`ifdef VECTOR_CHECKER_MASK_EN
  localparam int VEC_W_MUL = 2;
`else
  localparam int VEC_W_MUL = 1;
`endif
  localparam int CARE_LSB = 0;
  function automatic int vec_w(input int in_w, input int out_w);
    return in_w + VEC_W_MUL * out_w;
  endfunction
  function automatic int exp_lsb(input int out_w);
    return CARE_LSB + (VEC_W_MUL - 1) * out_w;
  endfunction
  function automatic int stim_lsb(input int out_w);
    return exp_lsb(out_w) + out_w;
  endfunction
endpackage

// File: rtl/vc_compare.sv
// vc_compare: combinational response compare, masked by care bits when VECTOR_CHECKER_MASK_EN is defined
module vc_compare #(
  parameter int OUT_W = 55
) (
  input  logic [OUT_W-1:0] got,
  input  logic [OUT_W-1:0] expected,
`ifdef VECTOR_CHECKER_MASK_EN
  input  logic [OUT_W-1:0] care,
`endif
  output logic             mismatch
);
`ifdef VECTOR_CHECKER_MASK_EN
  assign mismatch = |((got ^ expected) & care);
`else
  assign mismatch = got != expected;
`endif
endmodule

// File: rtl/vector_checker.sv
// vector_checker: memory-driven stimulus/compare engine with error counting and first-failure capture
// VECTOR_CHECKER_MASK_EN: vector words carry a per-bit care field in their LSBs
module vector_checker
  import vc_pkg::*;
#(
  parameter int IN_W   = 35,
  parameter int OUT_W  = 55,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 16,
  localparam int VEC_W = vec_w(IN_W, OUT_W)
) (
  input  logic              clk_test,
  input  logic              reset,
  input  logic              start,
  output logic              vec_rd,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [VEC_W-1:0]  vec_data,
  input  logic              vec_end,
  output logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   vec_count,
  output logic [ERR_W-1:0]  errors,
  output logic              fail_valid,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [OUT_W-1:0]  fail_got
);
  localparam int SL = stim_lsb(OUT_W);
  localparam int EL = exp_lsb(OUT_W);
  state_t state, nxt;
  logic [OUT_W-1:0] exp_q;
  logic [3:0] cnt;
  logic mismatch;
  logic at_end;
  logic launch;
`ifdef VECTOR_CHECKER_MASK_EN
  logic [OUT_W-1:0] care_q;
  vc_compare #(.OUT_W(OUT_W)) u_cmp (.got(dut_out), .expected(exp_q), .care(care_q), .mismatch(mismatch));
`else
  vc_compare #(.OUT_W(OUT_W)) u_cmp (.got(dut_out), .expected(exp_q), .mismatch(mismatch));
`endif
  assign at_end = vec_addr == ADDR_W'(DEPTH - 1);
  assign launch = start && (state == IDLE || state == DONE);
  assign vec_rd = state == FETCH;
  assign busy = state != IDLE && state != DONE;
  assign done = state == DONE;
  assign pass = done && errors == '0;
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE:  nxt = start ? FETCH : state;
      FETCH:       nxt = WAIT_DATA;
      WAIT_DATA:   nxt = vec_end ? DONE : APPLY;
      APPLY:       nxt = SETTLE_WAIT;
      SETTLE_WAIT: nxt = cnt == '0 ? CHECK : SETTLE_WAIT;
      CHECK:       nxt = at_end ? DONE : FETCH;
      default:     nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_test) begin
    if (!reset) begin
      state      <= IDLE;
      vec_addr   <= '0;
      dut_in     <= '0;
      exp_q      <= '0;
`ifdef VECTOR_CHECKER_MASK_EN
      care_q     <= '0;
`endif
      cnt        <= '0;
      vec_count  <= '0;
      errors     <= '0;
      fail_valid <= 1'b0;
      fail_addr  <= '0;
      fail_got   <= '0;
    end else begin
      state <= nxt;
      if (launch) begin
        vec_addr   <= '0;
        vec_count  <= '0;
        errors     <= '0;
        fail_valid <= 1'b0;
        fail_addr  <= '0;
        fail_got   <= '0;
      end
      // the end-marker word is never applied, so dut_in keeps the last real stimulus
      if (state == WAIT_DATA && !vec_end) begin
        dut_in <= vec_data[SL +: IN_W];
        exp_q  <= vec_data[EL +: OUT_W];
`ifdef VECTOR_CHECKER_MASK_EN
        care_q <= vec_data[CARE_LSB +: OUT_W];
`endif
      end
      if (state == APPLY) cnt <= 4'(SETTLE - 1);
      if (state == SETTLE_WAIT && cnt != '0) cnt <= cnt - 1'b1;
      if (state == CHECK) begin
        vec_count <= vec_count + 1'b1;
        if (mismatch && errors != '1) errors <= errors + 1'b1;
        if (mismatch && !fail_valid) begin
          fail_valid <= 1'b1;
          fail_addr  <= vec_addr;
          fail_got   <= dut_out;
        end
        if (!at_end) vec_addr <= vec_addr + 1'b1;
      end
    end
  end
endmodule
